// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle between two ALU clients and the nibble sequencer.
interface alu_seq_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_q;
    logic              rsp_cout;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_cout
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_cout
    );

endinterface

// File: rtl/alu_nibble_sequencer_addsub.sv
// Combinational 4-bit add/subtract slice: ripple full-adder path and a
// subtract path built from half/full subtractor cells.
module half_sub (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;

    half_sub u_hs0 (.a(a),  .b(b),   .d(d1), .bout(b1));
    half_sub u_hs1 (.a(d1), .b(bin), .d(d),  .bout(b2));

    assign bout = b1 | b2;
endmodule

module nibble_addsub_4
    import alu_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic [NIBBLE_W-1:0] q,
    output logic                cout
);
    logic [NIBBLE_W:0]   brw;
    logic [NIBBLE_W-1:0] diff;
    logic [NIBBLE_W:0]   sum;

    assign brw[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_sub
        full_sub u_fs (
            .a   (a[i]),
            .b   (b[i]),
            .bin (brw[i]),
            .d   (diff[i]),
            .bout(brw[i+1])
        );
    end

    assign sum  = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign q    = sub ? diff : sum[NIBBLE_W-1:0];
    assign cout = sub ? brw[NIBBLE_W] : sum[NIBBLE_W];
endmodule

// File: rtl/alu_nibble_sequencer.sv
// Round-robin shares one 4-bit add/subtract slice between two requesters,
// processing DATA_W-bit operations one nibble per cycle, LSB nibble first.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus,
    output logic      busy
);
    localparam int NIBBLES = DATA_W / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if ((DATA_W % NIBBLE_W) != 0 || DATA_W < NIBBLE_W) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 4 and at least 4");
    end

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                carry_q, carry_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   res_q, res_d;
    op_e                 op_q, op_d;
    logic                id_q, id_d;
    logic                last_q, last_d;

    logic                any_valid;
    logic                grant;
    logic [NIBBLE_W-1:0] slice_a, slice_b, slice_q;
    logic                slice_cout;

    // On contention the requester not served most recently wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    nibble_addsub_4 u_slice (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_q),
        .sub (op_q == OP_SUB),
        .q   (slice_q),
        .cout(slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        id_d    = id_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d     = grant ? bus.req1_a : bus.req0_a;
                    b_d     = grant ? bus.req1_b : bus.req0_b;
                    op_d    = op_e'(grant ? bus.req1_op : bus.req0_op);
                    id_d    = grant;
                    last_d  = grant;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_q;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= OP_ADD;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign bus.req0_ready = (state_q == IDLE) && any_valid && !grant;
    assign bus.req1_ready = (state_q == IDLE) && any_valid && grant;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_q      = res_q;
    assign bus.rsp_cout   = carry_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench: cycle model of the 16-bit sequencer plus directed
// literal checks, and a single directed case on a 4-bit instance.
module tb_alu_nibble_sequencer;

    localparam int DW  = 16;
    localparam int NIB = DW / 4;

    logic clk;
    logic rst;
    logic busy16, busy4;
    int   checks = 0;
    int   errors = 0;

    alu_seq_if #(.DATA_W(DW)) bus16 ();
    alu_seq_if #(.DATA_W(4))  bus4 ();

    alu_nibble_sequencer #(.DATA_W(DW)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16),
        .busy(busy16)
    );

    alu_nibble_sequencer #(.DATA_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4),
        .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] ref_op(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (op) return {(a < b), a - b};
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Behavioural model: cycles remaining until the result appears, plus the
    // pending result and the last-served requester.
    int            m_left;
    bit            m_resp;
    logic          m_last;
    logic          m_id;
    logic [DW:0]   m_res;
    logic          m_g;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_resp = 0;
            m_last = 1'b1;
            m_id   = 1'b0;
            m_res  = '0;
        end else if (m_resp) begin
            if (bus16.rsp_ready) m_resp = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_resp = 1;
        end else if (bus16.req0_valid || bus16.req1_valid) begin
            m_g = (bus16.req0_valid && bus16.req1_valid) ? ~m_last : bus16.req1_valid;
            m_res  = m_g ? ref_op(bus16.req1_op, bus16.req1_a, bus16.req1_b)
                         : ref_op(bus16.req0_op, bus16.req0_a, bus16.req0_b);
            m_id   = m_g;
            m_last = m_g;
            m_left = NIB;
        end
    end

    logic c_g;
    bit   c_idle;
    bit   c_any;

    always @(negedge clk) begin
        if (!rst) begin
            c_idle = !m_resp && (m_left == 0);
            c_any  = bus16.req0_valid || bus16.req1_valid;
            c_g    = (bus16.req0_valid && bus16.req1_valid) ? ~m_last : bus16.req1_valid;
            check("m_ready0", bus16.req0_ready, c_idle && c_any && !c_g);
            check("m_ready1", bus16.req1_ready, c_idle && c_any && c_g);
            check("m_rsp_valid", bus16.rsp_valid, m_resp);
            check("m_busy", busy16, !c_idle);
            if (m_resp) begin
                check("m_rsp_q", bus16.rsp_q, m_res[DW-1:0]);
                check("m_rsp_cout", bus16.rsp_cout, m_res[DW]);
                check("m_rsp_id", bus16.rsp_id, m_id);
            end
        end
    end

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout required event", nm);
    endtask

    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        ok  = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus16.rsp_valid) begin
                ok = 1;
                break;
            end
            lat++;
        end
    endtask

    task automatic run_op(input logic id, input logic op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp_q,
                          input logic exp_c);
        int lat;
        bit ok;
        @(posedge clk);
        #1;
        if (!id) begin
            bus16.req0_a = a; bus16.req0_b = b; bus16.req0_op = op; bus16.req0_valid = 1'b1;
        end else begin
            bus16.req1_a = a; bus16.req1_b = b; bus16.req1_op = op; bus16.req1_valid = 1'b1;
        end
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if ((id ? bus16.req1_ready : bus16.req0_ready) === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus16.req0_valid = 1'b0;
        bus16.req1_valid = 1'b0;
        bus16.req0_a = DW'($urandom); bus16.req0_b = DW'($urandom); bus16.req0_op = 1'($urandom);
        bus16.req1_a = DW'($urandom); bus16.req1_b = DW'($urandom); bus16.req1_op = 1'($urandom);
        if (!ok) begin
            timeout("accept");
            return;
        end
        wait_rsp(lat, ok);
        if (!ok) begin
            timeout("rsp_valid");
            return;
        end
        check("latency", lat, NIB);
        check("rsp_q", bus16.rsp_q, exp_q);
        check("rsp_cout", bus16.rsp_cout, exp_c);
        check("rsp_id", bus16.rsp_id, id);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  ok;
        int  got;
        logic [DW-1:0] arb_q [4];
        logic          arb_id[4];

        rst = 1'b1;
        bus16.req0_valid = 0; bus16.req0_a = '0; bus16.req0_b = '0; bus16.req0_op = 0;
        bus16.req1_valid = 0; bus16.req1_a = '0; bus16.req1_b = '0; bus16.req1_op = 0;
        bus16.rsp_ready  = 1'b1;
        bus4.req0_valid = 0; bus4.req0_a = '0; bus4.req0_b = '0; bus4.req0_op = 0;
        bus4.req1_valid = 0; bus4.req1_a = '0; bus4.req1_b = '0; bus4.req1_op = 0;
        bus4.rsp_ready  = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", bus16.rsp_valid, 0);
        check("rst_busy", busy16, 0);
        check("rst_rsp_q", bus16.rsp_q, 0);
        check("rst_rsp_id", bus16.rsp_id, 0);
        check("rst_rsp_cout", bus16.rsp_cout, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b0);
        run_op(1'b1, 1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1);
        run_op(1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        run_op(1'b1, 1'b1, 16'h1000, 16'h0001, 16'h0FFF, 1'b0);
        run_op(1'b0, 1'b0, 16'hA5C3, 16'h5A3D, 16'h0000, 1'b1);

        // Backpressure: result held for ten cycles with a competing request pending.
        @(posedge clk);
        #1;
        bus16.rsp_ready  = 1'b0;
        bus16.req0_a = 16'h00FF; bus16.req0_b = 16'h0001; bus16.req0_op = 1'b0;
        bus16.req0_valid = 1'b1;
        @(negedge clk);
        check("bp_accept", bus16.req0_ready, 1);
        @(posedge clk);
        #1;
        bus16.req0_valid = 1'b0;
        bus16.req1_a = 16'h0001; bus16.req1_b = 16'h0001; bus16.req1_op = 1'b0;
        bus16.req1_valid = 1'b1;
        wait_rsp(lat, ok);
        if (!ok) timeout("bp_rsp_valid");
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", bus16.rsp_valid, 1);
            check("bp_q", bus16.rsp_q, 16'h0100);
            check("bp_id", bus16.rsp_id, 0);
            check("bp_ready1", bus16.req1_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus16.rsp_ready  = 1'b1;
        bus16.req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_idle_busy", busy16, 0);
        check("bp_idle_valid", bus16.rsp_valid, 0);

        // Reset mid-operation after two nibbles have been processed.
        @(posedge clk);
        #1;
        bus16.req0_a = 16'h1111; bus16.req0_b = 16'h2222; bus16.req0_op = 1'b0;
        bus16.req0_valid = 1'b1;
        @(negedge clk);
        check("mr_accept", bus16.req0_ready, 1);
        @(posedge clk);
        #1;
        bus16.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mr_busy_before", busy16, 1);
        rst = 1'b1;
        #1;
        check("mr_busy", busy16, 0);
        check("mr_valid", bus16.rsp_valid, 0);
        check("mr_q", bus16.rsp_q, 0);
        check("mr_id", bus16.rsp_id, 0);
        check("mr_cout", bus16.rsp_cout, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mr_no_rsp", bus16.rsp_valid, 0);
        end
        run_op(1'b1, 1'b1, 16'h0009, 16'h0002, 16'h0007, 1'b0);

        // Arbitration from a fresh reset with both requesters always valid.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus16.req0_a = 16'h1234; bus16.req0_b = 16'h1111; bus16.req0_op = 1'b0;
        bus16.req1_a = 16'h1234; bus16.req1_b = 16'h1111; bus16.req1_op = 1'b1;
        bus16.req0_valid = 1'b1;
        bus16.req1_valid = 1'b1;
        got = 0;
        for (int n = 0; n < 60 && got < 4; n++) begin
            @(negedge clk);
            if (bus16.rsp_valid) begin
                arb_q[got]  = bus16.rsp_q;
                arb_id[got] = bus16.rsp_id;
                got++;
            end
        end
        @(posedge clk);
        #1;
        bus16.req0_valid = 1'b0;
        bus16.req1_valid = 1'b0;
        if (got < 4) begin
            timeout("arb_responses");
        end else begin
            for (int i = 0; i < 4; i++) begin
                check("arb_id", arb_id[i], i % 2);
                check("arb_q", arb_q[i], (i % 2) ? 16'h0123 : 16'h2345);
            end
        end
        repeat (NIB + 3) @(posedge clk);

        // Single-nibble instance: EXEC lasts one cycle.
        #1;
        bus4.req0_a = 4'hF; bus4.req0_b = 4'h1; bus4.req0_op = 1'b0;
        bus4.req0_valid = 1'b1;
        @(negedge clk);
        check("w4_accept", bus4.req0_ready, 1);
        @(posedge clk);
        #1;
        bus4.req0_valid = 1'b0;
        lat = 0;
        ok  = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus4.rsp_valid) begin
                ok = 1;
                break;
            end
            lat++;
        end
        if (!ok) begin
            timeout("w4_rsp_valid");
        end else begin
            check("w4_latency", lat, 1);
            check("w4_q", bus4.rsp_q, 4'h0);
            check("w4_cout", bus4.rsp_cout, 1);
            check("w4_id", bus4.rsp_id, 0);
        end
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
- Shares one 4-bit add/subtract slice between two requesters.
- Runs DATA_W-bit add/subtract operations nibble-serially, least-significant nibble first, and chains carry or borrow across cycles.
- Arbitrates requesters round-robin and returns each result over a valid/ready response channel.
- Sits between the ALU front-end clients and the 4-bit ripple add/subtract datapath.

Parameters:
- DATA_W, 16: operand and result width. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- NIBBLES, DATA_W/4: derived value, not overridable. Number of EXEC cycles per operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 is accepted this cycle.
- req0_a  in  DATA_W  requester 0 minuend / addend A.
- req0_b  in  DATA_W  requester 0 subtrahend / addend B.
- req0_op  in  1  requester 0 operation: 0 = add, 1 = subtract (A - B).
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  1  index of the requester that issued this result.
- rsp_q  out  DATA_W  result, modulo 2^DATA_W.
- rsp_cout  out  1  carry-out for add; borrow-out for subtract (1 when A < B unsigned).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, active-high, effective immediately and also mid-operation):
  - state = IDLE; rsp_valid = 0, rsp_id = 0, rsp_q = 0, rsp_cout = 0, busy = 0.
  - Nibble index, carry register and captured operands cleared.
  - Round-robin pointer set so that requester 0 has priority.
  - An operation in flight is discarded and no response is produced for it.
- States:
  - IDLE: waiting for a request.
  - EXEC: processing one nibble per cycle.
  - RESP: holding the result until the consumer takes it.
- IDLE:
  - Grant selection is combinational. If exactly one reqN_valid is high, grant N. If both are high, grant the requester that was not served most recently.
  - reqN_ready = (state == IDLE) && grant == N. The ready signals never depend combinationally on rsp_ready.
  - On the accept edge (valid && ready):
    - Capture a, b, op and id.
    - Set idx = 0 and the carry register to 0. The borrow-in for subtract is also 0.
    - Update the round-robin pointer.
    - Go to EXEC.
- EXEC:
  - Each edge applies the slice to nibble idx: {cout, q_n} = a_n +/- b_n +/- cin.
  - Write q_n into result bits [4*idx+3 : 4*idx], latch cout into the carry register, and increment idx.
  - On the edge that processes idx = NIBBLES-1, go to RESP.
  - Requests are ignored in EXEC: both reqN_ready are 0.
- RESP:
  - rsp_valid = 1. rsp_q, rsp_cout and rsp_id stay stable while rsp_ready = 0.
  - On an edge with rsp_ready = 1, go to IDLE. No new accept happens in that cycle.
  - Throughput: at most one operation per NIBBLES + 2 cycles.
- Latency: rsp_valid rises exactly NIBBLES cycles after the accept edge.
- Operand inputs may change freely after the accept edge without affecting the result.
- reqN_valid dropping without a handshake is legal; nothing is accepted in that case.
- With NIBBLES = 1, EXEC lasts exactly one cycle.

Decomposition:
- Package alu_seq_pkg holds:
  - the op_e enum (OP_ADD = 0, OP_SUB = 1);
  - the state_e enum (IDLE, EXEC, RESP);
  - the NIBBLE_W = 4 constant.
- Sub-module nibble_addsub_4 is purely combinational:
  - Inputs: a[3:0], b[3:0], cin, sub.
  - Outputs: q[3:0], cout.
  - In subtract mode, cin is the borrow-in and cout is the borrow-out.
  - The sequencer instantiates exactly one copy; that instance is the shared resource.
  - Internally it is built from the existing half and full subtractor cells (subtract path) plus a full-adder path (add path).

Test Plan (DATA_W = 16 unless stated):
- Subtract, no borrow: req0 sub A = 0x0005, B = 0x0003 -> rsp_q = 0x0002, rsp_cout = 0, rsp_id = 0, rsp_valid exactly 4 cycles after the accept edge.
- Borrow across all nibbles: req1 sub A = 0x0000, B = 0x0001 -> rsp_q = 0xFFFF, rsp_cout = 1. Also add A = 0xFFFF, B = 0x0001 -> rsp_q = 0x0000, rsp_cout = 1. Also sub A = 0x1000, B = 0x0001 -> rsp_q = 0x0FFF, rsp_cout = 0.
- Arbitration: both valid continuously after reset, req0 = add 0x1234 + 0x1111, req1 = sub 0x1234 - 0x1111 -> responses alternate rsp_id 0, 1, 0, 1 with rsp_q = 0x2345, 0x0123 repeated. reqN_ready is never high outside IDLE.
- Backpressure: hold rsp_ready = 0 for 10 cycles in RESP -> rsp_valid, rsp_q and rsp_id stable, req*_ready = 0. Raise rsp_ready -> IDLE on the next edge.
- Reset mid-op: assert rst during EXEC at idx = 2 -> all outputs are 0 immediately, no response appears after release, and the next operation (req1 sub 0x0009 - 0x0002) returns 0x0007 with correct latency.
- DATA_W = 4: add 0xF + 0x1 -> rsp_q = 0x0, rsp_cout = 1, rsp_valid 1 cycle after the accept edge.
